// File: rtl/regbank_dump_pkg.sv
// Shared register-bank geometry and the dump engine's FSM encoding.
package regbank_dump_pkg;

  localparam int unsigned NumRegs = 32;
  localparam int unsigned AddrW   = 5;
  localparam int unsigned DataW   = 32;
  localparam int unsigned IdxW    = AddrW + 1;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2
  } state_e;

endpackage

// File: rtl/regbank_dump.sv
// Walks register addresses 0..NumRegs-1 on a read port and streams each word with its address
// over a valid/ready interface.
module regbank_dump
  import regbank_dump_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             abort_i,
  output logic [AddrW-1:0] read_reg_o,
  input  logic [DataW-1:0] read_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [DataW-1:0] out_data_o,
  output logic [AddrW-1:0] out_addr_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam logic [IdxW-1:0]  LastIdx  = IdxW'(NumRegs - 1);
  localparam logic [AddrW-1:0] LastAddr = AddrW'(NumRegs - 1);

  state_e           state_q, state_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic             out_valid_q, out_valid_d;
  logic [DataW-1:0] out_data_q, out_data_d;
  logic [AddrW-1:0] out_addr_q, out_addr_d;
  logic             done_q, done_d;

  logic load, accept;

  assign accept = out_valid_q && out_ready_i;
  // The output slot refills whenever it is empty or being drained this cycle.
  assign load   = (state_q == StRun) && (!out_valid_q || out_ready_i);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (abort_i) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:  if (start_i) state_d = StRun;
        StRun:   if (load && (idx_q == LastIdx)) state_d = StDrain;
        StDrain: if (accept) state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_addr_d  = out_addr_q;
    done_d      = 1'b0;
    if (abort_i) begin
      idx_d       = '0;
      out_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: if (start_i) idx_d = '0;
        StRun: begin
          if (load) begin
            out_data_d  = read_data_i;
            out_addr_d  = idx_q[AddrW-1:0];
            out_valid_d = 1'b1;
            idx_d       = idx_q + IdxW'(1);
          end
        end
        StDrain: begin
          if (accept) begin
            out_valid_d = 1'b0;
            done_d      = 1'b1;
          end
        end
        default: idx_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_addr_q  <= out_addr_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    read_reg_o = '0;
    unique case (state_q)
      StRun:   read_reg_o = idx_q[AddrW-1:0];
      StDrain: read_reg_o = LastAddr;
      default: read_reg_o = '0;
    endcase
  end

  assign busy_o      = (state_q != StIdle);
  assign done_o      = done_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_addr_o  = out_addr_q;

endmodule

// File: tb/tb_regbank_dump.sv
// Scoreboard bench: directed dumps against a behavioural register bank on the read port.
module tb_regbank_dump;
  import regbank_dump_pkg::*;

  typedef struct packed {
    logic [AddrW-1:0] addr;
    logic [DataW-1:0] data;
  } word_t;

  logic             clk = 1'b0;
  logic             rst_n, start, abort, out_ready;
  logic [AddrW-1:0] read_reg, out_addr;
  logic [DataW-1:0] read_data, out_data;
  logic             out_valid, busy, done;

  logic [DataW-1:0] bank [NumRegs];
  assign read_data = bank[read_reg];

  always #5 clk = ~clk;

  regbank_dump u_dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .start_i     (start),
    .abort_i     (abort),
    .read_reg_o  (read_reg),
    .read_data_i (read_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .out_addr_o  (out_addr),
    .busy_o      (busy),
    .done_o      (done)
  );

  int checks = 0;
  int failures = 0;
  int done_count = 0;
  int accepted = 0;
  logic [AddrW-1:0] last_addr = '0;
  word_t exp_q[$];
  word_t exp_w;
  word_t stall_word;
  logic  stall_prev = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: words are taken when valid&&ready is seen mid-cycle, before the accepting edge.
  always @(negedge clk) begin
    if (done) done_count++;
    if (stall_prev && out_valid) begin
      check("stall_addr", 64'(out_addr), 64'(stall_word.addr));
      check("stall_data", 64'(out_data), 64'(stall_word.data));
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_word actual addr=%0d required=no word", out_addr);
      end else begin
        exp_w = exp_q.pop_front();
        check("word_addr", 64'(out_addr), 64'(exp_w.addr));
        check("word_data", 64'(out_data), 64'(exp_w.data));
      end
      accepted++;
      last_addr = out_addr;
    end
    stall_prev = out_valid && !out_ready;
    stall_word = '{addr: out_addr, data: out_data};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DataW-1:0] pattern(input int i);
    return DataW'(i) * 32'h0101_0101;
  endfunction

  task automatic push_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) exp_q.push_back('{addr: AddrW'(i), data: pattern(i)});
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    check("done_seen", 64'(done), 64'd1);
  endtask

  task automatic check_reset_vals();
    check("rst_read_reg", 64'(read_reg), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_data", 64'(out_data), 64'd0);
    check("rst_addr", 64'(out_addr), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
  endtask

  logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    int n, dc, acc0;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < NumRegs; i++) bank[i] = pattern(i);
    tick();
    tick();
    check_reset_vals();
    rst_n = 1'b1;
    tick();

    // Full dump with ready held high: Busy over edges 0..32, Done only at edge 33.
    push_range(0, 31);
    pulse_start();
    check("e0_busy", 64'(busy), 64'd1);
    check("e0_read_reg", 64'(read_reg), 64'd0);
    for (int k = 1; k <= 33; k++) begin
      tick();
      check("busy_window", 64'(busy), 64'(k <= 32));
      check("done_timing", 64'(done), 64'(k == 33));
      if (k == 1) check("e1_first_addr", 64'({out_valid, out_addr}), 64'({1'b1, 5'd0}));
    end
    tick();
    check("done_drop", 64'(done), 64'd0);
    check("q_empty_full", 64'(exp_q.size()), 64'd0);

    // Ready toggling 1,0,0,1.
    push_range(0, 31);
    acc0 = accepted;
    pulse_start();
    n = 0;
    while (!done && n < 200) begin
      out_ready = pat[n % 4];
      tick();
      n++;
    end
    out_ready = 1'b1;
    check("toggle_done", 64'(done), 64'd1);
    check("toggle_last_addr", 64'(last_addr), 64'd31);
    check("toggle_count", 64'(accepted - acc0), 64'd32);
    check("q_empty_toggle", 64'(exp_q.size()), 64'd0);
    tick();

    // Abort while addr 10 is presented (word 10 is handed over on that same edge).
    push_range(0, 10);
    pulse_start();
    n = 0;
    while (!(out_valid && out_addr == 5'd10) && n < 50) begin
      tick();
      n++;
    end
    check("abort_reach10", 64'(out_addr), 64'd10);
    dc = done_count;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_valid", 64'(out_valid), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    tick();
    check("abort_no_done", 64'(done_count - dc), 64'd0);
    check("q_empty_abort", 64'(exp_q.size()), 64'd0);
    push_range(0, 31);
    pulse_start();
    wait_done(40);
    check("q_empty_restart", 64'(exp_q.size()), 64'd0);
    tick();

    // Start mid-dump ignored; Start+Abort in idle ignored.
    push_range(0, 31);
    dc = done_count;
    pulse_start();
    repeat (5) tick();
    pulse_start();
    wait_done(40);
    tick();
    check("restart_ignored_busy", 64'(busy), 64'd0);
    check("restart_ignored_done", 64'(done_count - dc), 64'd1);
    check("q_empty_midstart", 64'(exp_q.size()), 64'd0);
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_busy", 64'(busy), 64'd0);
    check("start_abort_valid", 64'(out_valid), 64'd0);
    tick();
    check("start_abort_idle", 64'(busy), 64'd0);

    // Bank write of R5 during the cycle before addr 5 is captured.
    push_range(0, 4);
    exp_q.push_back('{addr: 5'd5, data: 32'hDEAD_BEEF});
    push_range(6, 31);
    pulse_start();
    repeat (5) tick();
    bank[5] = 32'hDEAD_BEEF;
    wait_done(40);
    bank[5] = pattern(5);
    check("q_empty_write", 64'(exp_q.size()), 64'd0);
    tick();

    // Reset while DRAIN holds word 31 stalled.
    push_range(0, 30);
    pulse_start();
    repeat (32) tick();
    out_ready = 1'b0;
    check("drain_valid", 64'(out_valid), 64'd1);
    check("drain_addr", 64'(out_addr), 64'd31);
    check("drain_read_reg", 64'(read_reg), 64'd31);
    tick();
    check("drain_hold", 64'({out_valid, busy}), 64'({1'b1, 1'b1}));
    dc = done_count;
    rst_n = 1'b0;
    tick();
    check_reset_vals();
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    check("rst_no_done", 64'(done_count - dc), 64'd0);
    check("rst_idle", 64'(busy), 64'd0);
    check("q_empty_rst", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
